// File: rtl/axi_mem_if_pkg.sv
// Shared AXI memory-interface definitions.
// Response codes, burst encodings and write FSM states.
package axi_mem_if_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] WRAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT_B
  } wr_state_t;

endpackage

// File: rtl/axi_write_only_ctrl.sv
// AXI4 write slave: AW/W/B bursts to single-port SRAM writes.
// One burst in flight; each granted W beat is one memory write.
module axi_write_only_ctrl
  import axi_mem_if_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_WDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_WDATA_WIDTH/8,
  parameter int MEM_ADDR_WIDTH     = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
  input  logic [7:0]                    AWLEN_i,
  input  logic [2:0]                    AWSIZE_i,
  input  logic [1:0]                    AWBURST_i,
  input  logic                          AWLOCK_i,
  input  logic [3:0]                    AWCACHE_i,
  input  logic [2:0]                    AWPROT_i,
  input  logic [3:0]                    AWREGION_i,
  input  logic [3:0]                    AWQOS_i,
  input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
  input  logic                          AWVALID_i,
  output logic                          AWREADY_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
  input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
  input  logic                          WLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0]    WUSER_i,
  input  logic                          WVALID_i,
  output logic                          WREADY_o,
  output logic [AXI4_ID_WIDTH-1:0]      BID_o,
  output logic [1:0]                    BRESP_o,
  output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
  output logic                          BVALID_o,
  input  logic                          BREADY_i,
  output logic                          MEM_CEN_o,
  output logic                          MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
  output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   MEM_Q_i,
  input  logic                          grant_i,
  output logic                          valid_o
);

  localparam int OFFSET = $clog2(AXI_NUMBYTES);

  wr_state_t                   state_q, state_d;
  logic [8:0]                  cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic [AXI4_ID_WIDTH-1:0]    id_q, id_d;
  logic [AXI4_USER_WIDTH-1:0]  user_q, user_d;
  logic [7:0]                  len_q, len_d;
  logic [1:0]                  burst_q, burst_d;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                        aw_take;
  logic                        unused_ok;

  assign unused_ok = ^{AWADDR_i, AWSIZE_i, AWLOCK_i, AWCACHE_i,
                       AWPROT_i, AWREGION_i, AWQOS_i, WUSER_i,
                       MEM_Q_i};

  assign MEM_A_o  = (burst_q == FIXED) ? addr_q
                  : addr_q + MEM_ADDR_WIDTH'(cnt_q);
  assign MEM_D_o  = WDATA_i;
  assign MEM_BE_o = WSTRB_i;
  assign BID_o    = id_q;
  assign BUSER_o  = user_q;

  // Next state, handshakes and memory strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    id_d      = id_q;
    user_d    = user_q;
    len_d     = len_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    aw_take   = 1'b0;
    AWREADY_o = 1'b0;
    WREADY_o  = 1'b0;
    BVALID_o  = 1'b0;
    BRESP_o   = OKAY;
    MEM_CEN_o = 1'b1;
    MEM_WEN_o = 1'b1;
    valid_o   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          AWREADY_o = 1'b1;
          aw_take   = AWVALID_i;
        end
        DATA: begin
          valid_o   = WVALID_i;
          MEM_CEN_o = ~WVALID_i;
          MEM_WEN_o = 1'b0;
          WREADY_o  = WVALID_i & grant_i;
          if (WVALID_i && grant_i) begin
            if (cnt_q == {1'b0, len_q}) begin
              state_d = WAIT_B;
              if (!WLAST_i) err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 9'd1;
              if (WLAST_i) err_d = 1'b1;
            end
          end
        end
        WAIT_B: begin
          BVALID_o  = 1'b1;
          BRESP_o   = err_q ? SLVERR : OKAY;
          AWREADY_o = BREADY_i;
          if (BREADY_i) begin
            state_d = IDLE;
            aw_take = AWVALID_i;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (aw_take) begin
      state_d = DATA;
      cnt_d   = '0;
      err_d   = (AWBURST_i == WRAP);
      id_d    = AWID_i;
      user_d  = AWUSER_i;
      len_d   = AWLEN_i;
      burst_d = AWBURST_i;
      addr_d  = AWADDR_i[MEM_ADDR_WIDTH+OFFSET-1:OFFSET];
    end
  end

  // State and latched AW fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= '0;
      user_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      id_q    <= id_d;
      user_q  <= user_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_axi_write_only_ctrl.sv
// Scoreboard bench for axi_write_only_ctrl.
// Writes and B responses are queued on drive, popped on output.
module tb_axi_write_only_ctrl;
  import axi_mem_if_pkg::*;

  typedef struct {
    logic [12:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } wexp_t;

  typedef struct {
    logic [15:0] id;
    logic [9:0]  user;
    logic [1:0]  resp;
  } bexp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] AWID_i = 0;
  logic [31:0] AWADDR_i = 0;
  logic [7:0]  AWLEN_i = 0;
  logic [2:0]  AWSIZE_i = 3;
  logic [1:0]  AWBURST_i = 0;
  logic [9:0]  AWUSER_i = 0;
  logic        AWVALID_i = 0;
  logic        AWREADY_o;
  logic [63:0] WDATA_i = 0;
  logic [7:0]  WSTRB_i = 0;
  logic        WLAST_i = 0;
  logic        WVALID_i = 0;
  logic        WREADY_o;
  logic [15:0] BID_o;
  logic [1:0]  BRESP_o;
  logic [9:0]  BUSER_o;
  logic        BVALID_o;
  logic        BREADY_i = 1;
  logic        MEM_CEN_o;
  logic        MEM_WEN_o;
  logic [12:0] MEM_A_o;
  logic [63:0] MEM_D_o;
  logic [7:0]  MEM_BE_o;
  logic        grant_i = 1;
  logic        valid_o;

  int total = 0;
  int bad = 0;
  wexp_t wq[$];
  bexp_t bq[$];

  axi_write_only_ctrl dut (
    .clk(clk), .rst(rst),
    .AWID_i(AWID_i), .AWADDR_i(AWADDR_i), .AWLEN_i(AWLEN_i),
    .AWSIZE_i(AWSIZE_i), .AWBURST_i(AWBURST_i),
    .AWLOCK_i(1'b0), .AWCACHE_i(4'd0), .AWPROT_i(3'd0),
    .AWREGION_i(4'd0), .AWQOS_i(4'd0), .AWUSER_i(AWUSER_i),
    .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
    .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WLAST_i(WLAST_i),
    .WUSER_i(10'd0), .WVALID_i(WVALID_i), .WREADY_o(WREADY_o),
    .BID_o(BID_o), .BRESP_o(BRESP_o), .BUSER_o(BUSER_o),
    .BVALID_o(BVALID_o), .BREADY_i(BREADY_i),
    .MEM_CEN_o(MEM_CEN_o), .MEM_WEN_o(MEM_WEN_o),
    .MEM_A_o(MEM_A_o), .MEM_D_o(MEM_D_o), .MEM_BE_o(MEM_BE_o),
    .MEM_Q_i(64'd0), .grant_i(grant_i), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Memory-write monitor
  always @(negedge clk) begin
    if (WREADY_o) begin
      if (wq.size() == 0) begin
        chk("wr_extra", {51'd0, MEM_A_o}, 64'h1_0000);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        chk("wr_strobe", {62'd0, MEM_CEN_o, MEM_WEN_o}, 64'd0);
        chk("wr_addr", {51'd0, MEM_A_o}, {51'd0, e.a});
        chk("wr_data", MEM_D_o, e.d);
        chk("wr_be", {56'd0, MEM_BE_o}, {56'd0, e.be});
      end
    end
  end

  // B-response monitor
  always @(negedge clk) begin
    if (BVALID_o && BREADY_i) begin
      if (bq.size() == 0) begin
        chk("b_extra", {63'd0, BVALID_o}, 64'd0);
      end else begin
        bexp_t e;
        e = bq.pop_front();
        chk("b_id", {48'd0, BID_o}, {48'd0, e.id});
        chk("b_user", {54'd0, BUSER_o}, {54'd0, e.user});
        chk("b_resp", {62'd0, BRESP_o}, {62'd0, e.resp});
      end
    end
  end

  task automatic do_aw(input logic [15:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [1:0] bt,
                       input logic [9:0] user);
    int n;
    AWID_i = id; AWADDR_i = addr; AWLEN_i = len;
    AWBURST_i = bt; AWUSER_i = user; AWVALID_i = 1;
    #1;
    n = 0;
    while (!AWREADY_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!AWREADY_o) chk("aw_timeout", 0, 1);
    @(posedge clk); #1;
    AWVALID_i = 0;
  endtask

  task automatic burst(input logic [15:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [1:0] bt,
                       input logic [9:0] user, input int early_last,
                       input int stall_beat, input bit waitb);
    bexp_t b;
    wexp_t w;
    logic [12:0] base;
    int n;
    base = addr[15:3];
    b.id = id; b.user = user;
    b.resp = (bt == WRAP || early_last >= 0) ? SLVERR : OKAY;
    bq.push_back(b);
    do_aw(id, addr, len, bt, user);
    for (int i = 0; i <= int'(len); i++) begin
      w.a  = (bt == FIXED) ? base : base + 13'(i);
      w.d  = {$urandom, $urandom};
      w.be = 8'($urandom);
      wq.push_back(w);
      WDATA_i = w.d; WSTRB_i = w.be;
      WLAST_i = (i == int'(len)) ^ (i == early_last);
      WVALID_i = 1;
      if (i == stall_beat) begin
        grant_i = 0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_wready", {63'd0, WREADY_o}, 64'd0);
          chk("stall_addr", {51'd0, MEM_A_o}, {51'd0, w.a});
        end
        @(posedge clk); #1;
        grant_i = 1;
      end
      #1;
      n = 0;
      while (!WREADY_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!WREADY_o) chk("w_timeout", 0, 1);
      @(posedge clk); #1;
    end
    WVALID_i = 0; WLAST_i = 0;
    @(negedge clk);
    chk("b_latency", {63'd0, BVALID_o}, 64'd1);
    if (waitb) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    AWVALID_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", {63'd0, AWREADY_o}, 64'd0);
    chk("rst_bvalid", {63'd0, BVALID_o}, 64'd0);
    chk("rst_cen", {63'd0, MEM_CEN_o}, 64'd1);
    chk("rst_wen", {63'd0, MEM_WEN_o}, 64'd1);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    AWVALID_i = 0;
    @(posedge clk); #1;
    rst = 0;
    WVALID_i = 1;
    @(negedge clk);
    chk("idle_awready", {63'd0, AWREADY_o}, 64'd1);
    chk("idle_wready", {63'd0, WREADY_o}, 64'd0);
    chk("idle_cen", {63'd0, MEM_CEN_o}, 64'd1);
    WVALID_i = 0;
    @(posedge clk); #1;

    burst(16'h1234, 32'h40, 8'd0, INCR, 10'h2A, -1, -1, 1);
    burst(16'h0007, 32'h100, 8'd3, INCR, 10'h011, -1, -1, 1);
    burst(16'h0008, 32'h100, 8'd3, INCR, 10'h012, -1, 1, 1);
    burst(16'h0009, 32'h80, 8'd1, INCR, 10'h013, 0, -1, 1);
    burst(16'h000A, 32'h200, 8'd2, FIXED, 10'h014, -1, -1, 1);
    burst(16'h000B, 32'h300, 8'd2, WRAP, 10'h015, -1, -1, 1);

    BREADY_i = 0;
    burst(16'hBEEF, 32'h400, 8'd1, INCR, 10'h3FF, -1, -1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_bvalid", {63'd0, BVALID_o}, 64'd1);
      chk("bp_bid", {48'd0, BID_o}, 64'hBEEF);
      chk("bp_bresp", {62'd0, BRESP_o}, {62'd0, OKAY});
    end
    @(posedge clk); #1;
    BREADY_i = 1;
    AWVALID_i = 1;
    #1;
    chk("b2b_awready", {63'd0, AWREADY_o}, 64'd1);
    burst(16'hC0DE, 32'h500, 8'd2, INCR, 10'h001, -1, -1, 1);

    do_aw(16'h00DD, 32'h600, 8'd3, INCR, 10'h0);
    begin
      wexp_t w;
      w.a = 13'h0C0; w.d = 64'hDEAD_0000_BEEF_0001; w.be = 8'h0F;
      wq.push_back(w);
      WDATA_i = w.d; WSTRB_i = w.be; WVALID_i = 1; WLAST_i = 0;
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1;
    @(negedge clk);
    chk("mrst_cen", {63'd0, MEM_CEN_o}, 64'd1);
    chk("mrst_wready", {63'd0, WREADY_o}, 64'd0);
    chk("mrst_bvalid", {63'd0, BVALID_o}, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_awready", {63'd0, AWREADY_o}, 64'd1);
    chk("post_rst_cen", {63'd0, MEM_CEN_o}, 64'd1);
    chk("post_rst_bvalid", {63'd0, BVALID_o}, 64'd0);
    WVALID_i = 0;
    @(posedge clk); #1;

    burst(16'h0F0F, 32'hFFF8, 8'd1, INCR, 10'h055, -1, -1, 1);
    burst(16'h0101, 32'h1000, 8'd255, INCR, 10'h066, -1, -1, 1);

    repeat (3) @(posedge clk);
    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("bq_empty", 64'(bq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
